// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame geometry and the DDS modulus.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // baudrate is in units of 100 baud, so the accumulator wraps at CLK_FREQ/100.
  function automatic logic [31:0] acc_modulus(input int clk_freq);
    return 32'(clk_freq / 100);
  endfunction

endpackage

// File: rtl/uart_dds_tick.sv
// Phase-accumulator baud x16 tick generator; enable_16 is registered, one cycle wide.
// Free-running, no backpressure; baudrate=0 stops the ticks.
module uart_dds_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] baudrate,
  output logic        enable_16
);

  localparam logic [31:0] MODULUS = acc_modulus(CLK_FREQ);

  logic [31:0] acc;
  logic [32:0] sum;
  logic [32:0] wrapped;

  // 33 bits so the carry out of a near-full accumulator is never lost.
  assign sum     = {1'b0, acc} + {13'd0, baudrate, 4'd0};
  assign wrapped = sum - {1'b0, MODULUS};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      acc       <= 32'd0;
      enable_16 <= 1'b0;
    end else if (sum >= {1'b0, MODULUS}) begin
      acc       <= wrapped[31:0];
      enable_16 <= 1'b1;
    end else begin
      acc       <= sum[31:0];
      enable_16 <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_dds_transceiver.sv
// Full-duplex 8N1 UART with DDS baud generator; tx starts the cycle after tx_wr, rx_done 2-3 clocks after mid-stop.
// No backpressure: tx_wr while busy is dropped, and received bytes overwrite rx_data unconditionally.
module uart_dds_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] baudrate,
  input  logic        uart_rx,
  output logic        uart_tx,
  input  logic [7:0]  tx_data,
  input  logic        tx_wr,
  output logic        tx_done,
  output logic        tx_busy,
  output logic [7:0]  rx_data,
  output logic        rx_done,
  output logic        rx_error,
  output logic        enable_16
);

  localparam logic [3:0] TICK_LAST    = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID     = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] TX_BIT_LAST  = 4'(DATA_BITS + 1);
  localparam logic [2:0] RX_BIT_LAST  = 3'(DATA_BITS - 1);

  uart_dds_tick #(
    .CLK_FREQ (CLK_FREQ)
  ) u_tick (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .baudrate  (baudrate),
    .enable_16 (enable_16)
  );

  tx_state_t  tx_state;
  logic [8:0] tx_shift;
  logic [3:0] tx_tick_cnt;
  logic [3:0] tx_bit_cnt;

  // The start bit goes straight to uart_tx; tx_shift holds data bits then the stop bit.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_state    <= TX_IDLE;
      tx_shift    <= '1;
      tx_tick_cnt <= 4'd0;
      tx_bit_cnt  <= 4'd0;
      uart_tx     <= 1'b1;
      tx_done     <= 1'b0;
      tx_busy     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_wr) begin
            tx_shift    <= {1'b1, tx_data};
            tx_tick_cnt <= 4'd0;
            tx_bit_cnt  <= 4'd0;
            uart_tx     <= 1'b0;
            tx_busy     <= 1'b1;
            tx_state    <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (enable_16) begin
            if (tx_tick_cnt == TICK_LAST) begin
              tx_tick_cnt <= 4'd0;
              if (tx_bit_cnt == TX_BIT_LAST) begin
                uart_tx  <= 1'b1;
                tx_done  <= 1'b1;
                tx_busy  <= 1'b0;
                tx_state <= TX_IDLE;
              end else begin
                uart_tx    <= tx_shift[0];
                tx_shift   <= {1'b1, tx_shift[8:1]};
                tx_bit_cnt <= tx_bit_cnt + 4'd1;
              end
            end else begin
              tx_tick_cnt <= tx_tick_cnt + 4'd1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  rx_state_t  rx_state;
  logic [7:0] rx_shift;
  logic [3:0] rx_tick_cnt;
  logic [2:0] rx_bit_cnt;

  // Returning to IDLE at mid-stop leaves half a bit to catch the next start edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_state    <= RX_IDLE;
      rx_shift    <= 8'd0;
      rx_tick_cnt <= 4'd0;
      rx_bit_cnt  <= 3'd0;
      rx_data     <= 8'd0;
      rx_done     <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      rx_done  <= 1'b0;
      rx_error <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (enable_16 && !rx_sync) begin
            rx_tick_cnt <= 4'd0;
            rx_state    <= RX_START;
          end
        end
        RX_START: begin
          if (enable_16) begin
            if (rx_tick_cnt == TICK_MID) begin
              rx_tick_cnt <= 4'd0;
              rx_bit_cnt  <= 3'd0;
              rx_state    <= rx_sync ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick_cnt <= rx_tick_cnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (enable_16) begin
            if (rx_tick_cnt == TICK_LAST) begin
              rx_tick_cnt <= 4'd0;
              rx_shift    <= {rx_sync, rx_shift[7:1]};
              if (rx_bit_cnt == RX_BIT_LAST) begin
                rx_state <= RX_STOP;
              end else begin
                rx_bit_cnt <= rx_bit_cnt + 3'd1;
              end
            end else begin
              rx_tick_cnt <= rx_tick_cnt + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (enable_16) begin
            if (rx_tick_cnt == TICK_LAST) begin
              rx_tick_cnt <= 4'd0;
              if (rx_sync) begin
                rx_data  <= rx_shift;
                rx_done  <= 1'b1;
                rx_state <= RX_IDLE;
              end else begin
                rx_error <= 1'b1;
                rx_state <= RX_WAIT_HIGH;
              end
            end else begin
              rx_tick_cnt <= rx_tick_cnt + 4'd1;
            end
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dds_transceiver.sv
// Scoreboard bench: byte-level model of the line and loopback receiver, checked by independent monitors.
`timescale 1ns/1ps
module tb_uart_dds_transceiver;

  logic        sys_clk  = 1'b0;
  logic        sys_rst  = 1'b1;
  logic [15:0] baudrate = 16'd10000;
  logic        loop_en  = 1'b1;
  logic        rx_drv   = 1'b1;
  logic [7:0]  tx_data  = 8'h00;
  logic        tx_wr    = 1'b0;
  logic        uart_rx, uart_tx, tx_done, tx_busy, rx_done, rx_error, enable_16;
  logic [7:0]  rx_data;

  uart_dds_transceiver #(.CLK_FREQ(50_000_000)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .baudrate  (baudrate),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .tx_done   (tx_done),
    .tx_busy   (tx_busy),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_error  (rx_error),
    .enable_16 (enable_16)
  );

  assign uart_rx = loop_en ? uart_tx : rx_drv;
  always #10 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] line_exp[$];
  logic [7:0] last_good = 8'h00;
  logic [7:0] exp_b;
  int err_pending = 0;
  int tx_done_cnt = 0, rx_done_cnt = 0, rx_err_cnt = 0, line_cnt = 0;
  int rst_gen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Called on a negedge; accept says whether the TX should take this byte.
  task automatic uart_write(input logic [7:0] d, input bit accept);
    tx_data = d;
    tx_wr   = 1'b1;
    if (accept) begin
      line_exp.push_back(d);
      if (loop_en) rx_exp.push_back(d);
    end
    @(negedge sys_clk);
    tx_wr = 1'b0;
  endtask

  task automatic wait_tx_done(input string name, output int lat);
    lat = 1;
    while (tx_done !== 1'b1) begin
      @(negedge sys_clk);
      lat++;
      if (lat > 800) begin
        fail(name, "tx_done not seen within 800 cycles, required a pulse");
        return;
      end
    end
  endtask

  // Ideal 1 Mbaud source at 50 MHz: 50 clocks per bit.
  task automatic drive_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      settle(50);
    end
    rx_drv = 1'b1;
  endtask

  always @(posedge sys_clk) if (sys_rst) rst_gen <= rst_gen + 1;

  always @(negedge sys_clk) begin
    if (sys_rst === 1'b0) begin
      if (tx_done === 1'b1) tx_done_cnt++;
      if (rx_done === 1'b1) begin
        rx_done_cnt++;
        if (rx_exp.size() == 0) begin
          fail("rx_unexpected_byte", $sformatf("got 0x%02h, required no byte", rx_data));
        end else begin
          exp_b = rx_exp.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, exp_b});
          last_good = exp_b;
        end
      end
      if (rx_error === 1'b1) begin
        rx_err_cnt++;
        if (err_pending == 0) fail("rx_unexpected_error", "got rx_error, required none");
        else err_pending--;
      end
    end
  end

  // Samples uart_tx mid-bit at 50 clocks per bit from the falling start edge.
  initial begin : line_decoder
    logic [7:0] b;
    logic       start_bit, stop_bit;
    int         g;
    forever begin
      @(negedge uart_tx);
      if (sys_rst !== 1'b0) continue;
      g = rst_gen;
      settle(25);
      start_bit = uart_tx;
      for (int i = 0; i < 8; i++) begin
        settle(50);
        b[i] = uart_tx;
      end
      settle(50);
      stop_bit = uart_tx;
      if (g == rst_gen) begin
        line_cnt++;
        check("line_start_bit", {31'd0, start_bit}, 32'd0);
        check("line_stop_bit", {31'd0, stop_bit}, 32'd1);
        if (line_exp.size() == 0)
          fail("line_unexpected_byte", $sformatf("got 0x%02h, required no byte", b));
        else
          check("line_byte", {24'd0, b}, {24'd0, line_exp.pop_front()});
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation still running at 2 ms, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int cnt, last, gap, gmin, gmax, lat, t0, r0, e0, l0;
    logic [7:0] stream [7];
    stream = '{8'hD5, 8'h05, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};

    settle(4);
    check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("reset_tx_done", {31'd0, tx_done}, 32'd0);
    check("reset_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("reset_rx_done", {31'd0, rx_done}, 32'd0);
    check("reset_rx_error", {31'd0, rx_error}, 32'd0);
    check("reset_enable_16", {31'd0, enable_16}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    sys_rst = 1'b0;

    // 16*10000 / 500000 = 0.32 ticks per clock
    cnt = 0; last = -1; gmin = 1000; gmax = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      if (enable_16 === 1'b1) begin
        cnt++;
        if (last >= 0) begin
          gap = i - last;
          if (gap < gmin) gmin = gap;
          if (gap > gmax) gmax = gap;
        end
        last = i;
      end
    end
    check("tick_count_1000", cnt, 320);
    check("tick_gap_min", gmin, 3);
    check("tick_gap_max", gmax, 4);

    baudrate = 16'd0;
    settle(2);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (enable_16 === 1'b1) cnt++;
    end
    check("tick_count_baud0", cnt, 0);
    baudrate = 16'd10000;
    settle(5);

    t0 = tx_done_cnt; r0 = rx_done_cnt; l0 = line_cnt;
    uart_write(8'hD5, 1'b1);
    check("busy_after_write", {31'd0, tx_busy}, 32'd1);
    wait_tx_done("loop_tx_done", lat);
    check("loop_tx_done_latency_ok", {31'd0, (lat >= 495 && lat <= 512)}, 32'd1);
    settle(50);
    check("loop_tx_done_count", tx_done_cnt - t0, 1);
    check("loop_rx_done_count", rx_done_cnt - r0, 1);
    check("loop_line_count", line_cnt - l0, 1);

    r0 = rx_done_cnt;
    uart_write(stream[0], 1'b1);
    for (int i = 1; i < 7; i++) begin
      wait_tx_done("stream_tx_done", lat);
      uart_write(stream[i], 1'b1);
    end
    wait_tx_done("stream_tx_done_last", lat);
    settle(100);
    check("stream_rx_done_count", rx_done_cnt - r0, 7);
    check("stream_rx_queue_empty", rx_exp.size(), 0);

    r0 = rx_done_cnt;
    for (int i = 0; i < 6; i++) begin
      settle($urandom_range(1, 20));
      uart_write(8'($urandom_range(0, 255)), 1'b1);
      wait_tx_done("random_tx_done", lat);
    end
    settle(100);
    check("random_rx_done_count", rx_done_cnt - r0, 6);

    loop_en = 1'b0;
    settle(20);
    r0 = rx_done_cnt; e0 = rx_err_cnt;
    err_pending++;
    drive_frame(8'h00, 1'b0);
    settle(100);
    check("frame_err_count", rx_err_cnt - e0, 1);
    check("frame_err_no_done", rx_done_cnt - r0, 0);
    check("frame_err_rx_data_held", {24'd0, rx_data}, {24'd0, last_good});
    rx_exp.push_back(8'h01);
    drive_frame(8'h01, 1'b1);
    settle(100);
    check("frame_recover_done", rx_done_cnt - r0, 1);

    r0 = rx_done_cnt; e0 = rx_err_cnt;
    rx_drv = 1'b0;
    settle(10);
    rx_drv = 1'b1;
    settle(300);
    check("glitch_no_done", rx_done_cnt - r0, 0);
    check("glitch_no_error", rx_err_cnt - e0, 0);
    loop_en = 1'b1;
    settle(20);

    t0 = tx_done_cnt; r0 = rx_done_cnt; l0 = line_cnt;
    uart_write(8'hAA, 1'b1);
    settle($urandom_range(50, 300));
    check("busy_mid_frame", {31'd0, tx_busy}, 32'd1);
    uart_write(8'h55, 1'b0);
    wait_tx_done("busy_tx_done", lat);
    settle(600);
    check("busy_tx_done_count", tx_done_cnt - t0, 1);
    check("busy_rx_done_count", rx_done_cnt - r0, 1);
    check("busy_line_count", line_cnt - l0, 1);

    t0 = tx_done_cnt; r0 = rx_done_cnt; e0 = rx_err_cnt;
    uart_write(8'hEC, 1'b1);
    settle(270);
    check("pre_reset_line_low", {31'd0, uart_tx}, 32'd0);
    sys_rst = 1'b1;
    rx_exp.delete();
    line_exp.delete();
    err_pending = 0;
    last_good = 8'h00;
    @(negedge sys_clk);
    check("reset_mid_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("reset_mid_tx_busy", {31'd0, tx_busy}, 32'd0);
    settle(2);
    sys_rst = 1'b0;
    settle(600);
    check("reset_mid_no_tx_done", tx_done_cnt - t0, 0);
    check("reset_mid_no_rx_done", rx_done_cnt - r0, 0);
    check("reset_mid_no_rx_error", rx_err_cnt - e0, 0);
    check("reset_mid_rx_data", {24'd0, rx_data}, 32'd0);

    t0 = tx_done_cnt; r0 = rx_done_cnt; l0 = line_cnt;
    uart_write(8'hA5, 1'b1);
    wait_tx_done("reset_recover_tx_done", lat);
    settle(100);
    check("reset_recover_tx_done_count", tx_done_cnt - t0, 1);
    check("reset_recover_rx_done_count", rx_done_cnt - r0, 1);
    check("reset_recover_line_count", line_cnt - l0, 1);

    settle(100);
    check("final_rx_queue_empty", rx_exp.size(), 0);
    check("final_line_queue_empty", line_exp.size(), 0);
    check("final_err_pending", err_pending, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_dds_transceiver.md
# uart_dds_transceiver

- Full-duplex 8N1 UART with a built-in DDS baud-tick generator.
- Sits between the host/AVR serial pins and the packet-level framers (s3g receiver/transmitter), which exchange single bytes with it through strobe handshakes.
- The baud rate is a run-time input in units of 100 baud, so one instance covers both the AVR link and the external link.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock in Hz. Must be a multiple of 100.
- `sys_clk`  in  1: system clock. All logic is on the rising edge.
- `sys_rst`  in  1: reset, synchronous, active-high.
- `baudrate`  in  16: baud rate / 100. For example, 10000 selects 1 Mbaud. It is sampled continuously.
- `uart_rx`  in  1: serial input, asynchronous. Idle level is high.
- `uart_tx`  out  1: serial output. Idle level is high.
- `tx_data`  in  8: byte to send. Sampled on the cycle `tx_wr`=1.
- `tx_wr`  in  1: single-cycle write strobe.
- `tx_done`  out  1: one-cycle pulse when the stop bit of a byte has finished.
- `tx_busy`  out  1: high from the cycle after an accepted `tx_wr` until `tx_done`.
- `rx_data`  out  8: last byte received correctly. Holds its value until the next good byte.
- `rx_done`  out  1: one-cycle pulse when `rx_data` is updated.
- `rx_error`  out  1: one-cycle pulse on a framing error (stop bit sampled low).
- `enable_16`  out  1: baud×16 tick, one cycle wide. Exported for other users.

## Operation
- **Baud generator**
  - Phase accumulator `acc`, range [0, CLK_FREQ/100).
  - Each cycle: `acc += 16*baudrate`.
  - If the sum is ≥ CLK_FREQ/100, subtract CLK_FREQ/100 and pulse `enable_16`.
  - The average rate is exact; jitter is ≤1 clock.
  - Use at least a 32-bit intermediate.
  - `baudrate`=0 means no ticks, and both state machines freeze.
- **Transmitter**
  - States: IDLE, SHIFT.
  - A `tx_wr` in IDLE latches `{1'b1, tx_data, 1'b0}`. `uart_tx` drives the start bit from the next cycle.
  - Each bit lasts exactly 16 `enable_16` ticks. Bits go out LSB first, then a stop bit of 1.
  - After the 160th tick: `tx_done` pulses, `uart_tx` is 1, and the state returns to IDLE.
  - A `tx_wr` during SHIFT is ignored, and the byte is lost.
  - A `tx_wr` in the same cycle as `tx_done` is accepted.
- **Receiver**
  - `uart_rx` passes through a 2-flop synchronizer.
  - States: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on a tick with the synced line low, go to START with the tick counter at 0.
  - START: at tick 8, if the line is high it was a false start, so return to IDLE. Otherwise go to DATA.
  - DATA: sample every 16 ticks (mid-bit), shifting LSB first for 8 bits.
  - STOP, line high when sampled: update `rx_data`, pulse `rx_done`, go to IDLE.
  - STOP, line low when sampled: pulse `rx_error`, leave `rx_data` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: return to IDLE once the line is high.
- TX and RX are fully independent. Simultaneous operation is allowed.

## Timing
- Reset values: `uart_tx`=1; `tx_done`, `tx_busy`, `rx_done`, `rx_error`, `enable_16`=0; `rx_data`=0; `acc`=0; both FSMs in IDLE.
- Reset asserted mid-byte aborts immediately. `uart_tx` returns high on the next edge and no done pulse is issued.
- The strobe outputs (`tx_done`, `rx_done`, `rx_error`) are registered and exactly one cycle wide.
- At most one strobe per byte.
- `rx_done` asserts 2–3 clocks after the tick on which the mid-stop sample is taken (synchronizer plus register).
- Because the receiver resynchronizes at mid-stop, back-to-back frames are received with no lost bytes.

## Structure
- Package `uart_pkg`:
  - TX and RX state enums.
  - `OVERSAMPLE`=16 and `DATA_BITS`=8.
  - A function computing the accumulator modulus from `CLK_FREQ`.
- Sub-module `uart_dds_tick`: the baud generator, parameters `CLK_FREQ` plus `sys_clk`, `sys_rst`, `baudrate` → `enable_16`.
- TX and RX FSMs live in the top module.

## Test plan
- **Tick rate:** `CLK_FREQ`=50e6, `baudrate`=10000 → exactly 320 `enable_16` pulses in 1000 clocks, with every gap 3 or 4 clocks.
- **Loopback** (`uart_tx`→`uart_rx`), 1 Mbaud:
  - Write 0xD5 → `uart_tx` low for 50 clocks, then bits 1,0,1,0,1,0,1,1, then stop.
  - `tx_done` at about 500 clocks.
  - `rx_done` with `rx_data`=0xD5.
- **Packet stream:** back-to-back writes of D5 05 12 13 14 15 16, each issued on its `tx_done` → 7 `rx_done` pulses with matching bytes in order, none missing.
- **Framing error:** drive a frame of 0x00 with the stop bit low → `rx_error` pulse, no `rx_done`, `rx_data` unchanged. The next valid 0x01 is received.
- **Glitch and busy:**
  - A 10-clock low pulse on `uart_rx` → no strobes.
  - A `tx_wr` of 0x55 while busy sending 0xAA → only 0xAA appears on the line.
- **Reset mid-frame:** assert `sys_rst` during bit 4 of a transmit → `uart_tx`=1 the next cycle, no `tx_done`. A new write afterwards transmits normally.
